// File: rtl/vx_bank_req_arb.sv
// vx_bank_req_arb: admits one bank-matching request per cycle (round-robin) into a
// registered bank port, bounds in-flight requests and routes responses by requester index.
module vx_bank_req_arb #(
    parameter int unsigned NUM_REQS    = 4,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned TAG_WIDTH   = 8,
    parameter int unsigned SEL_BITS    = 2,
    parameter int unsigned SEL_POS     = 2,
    parameter int unsigned BANK_ID     = 0,
    parameter int unsigned MAX_PENDING = 4,
    parameter int unsigned IDX_W       = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQS-1:0]            req_valid,
    input  logic [NUM_REQS-1:0]            req_rw,
    input  logic [NUM_REQS*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQS*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQS*TAG_WIDTH-1:0]  req_tag,
    output logic [NUM_REQS-1:0]            req_ready,
    output logic                           bank_req_valid,
    output logic                           bank_req_rw,
    output logic [ADDR_WIDTH-SEL_BITS-1:0] bank_req_addr,
    output logic [DATA_WIDTH-1:0]          bank_req_data,
    output logic [TAG_WIDTH+IDX_W-1:0]     bank_req_tag,
    input  logic                           bank_req_ready,
    input  logic                           bank_rsp_valid,
    input  logic [DATA_WIDTH-1:0]          bank_rsp_data,
    input  logic [TAG_WIDTH+IDX_W-1:0]     bank_rsp_tag,
    output logic                           bank_rsp_ready,
    output logic [NUM_REQS-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]          rsp_data,
    output logic [TAG_WIDTH-1:0]           rsp_tag,
    input  logic [NUM_REQS-1:0]            rsp_ready
);

    localparam int unsigned OUT_AW = ADDR_WIDTH - SEL_BITS;
    localparam int unsigned OTAG_W = TAG_WIDTH + IDX_W;
    localparam int unsigned CNT_W  = $clog2(MAX_PENDING + 1);

    typedef struct packed {
        logic                  rw;
        logic [OUT_AW-1:0]     addr;
        logic [DATA_WIDTH-1:0] data;
        logic [OTAG_W-1:0]     tag;
    } bank_req_t;

    logic [NUM_REQS-1:0] eligible;
    logic [OUT_AW-1:0]   strip_addr [NUM_REQS];

    // Per-requester bank match and select-field removal.
    for (genvar i = 0; i < NUM_REQS; i++) begin : g_req
        logic [ADDR_WIDTH-1:0] addr;
        assign addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];

        if (SEL_BITS == 0) begin : g_nosel
            assign eligible[i]   = req_valid[i];
            assign strip_addr[i] = addr;
        end else begin : g_sel
            assign eligible[i] = req_valid[i] &&
                                 (addr[SEL_POS +: SEL_BITS] == SEL_BITS'(BANK_ID));
            if (SEL_POS == 0) begin : g_low
                assign strip_addr[i] = addr[ADDR_WIDTH-1:SEL_BITS];
            end else if (SEL_POS + SEL_BITS < ADDR_WIDTH) begin : g_mid
                assign strip_addr[i] = {addr[ADDR_WIDTH-1:SEL_POS+SEL_BITS], addr[SEL_POS-1:0]};
            end else begin : g_top
                assign strip_addr[i] = addr[SEL_POS-1:0];
            end
        end
    end

    logic                 req_valid_q, req_valid_d;
    bank_req_t            req_q, req_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]     pending_q, pending_d;

    logic [NUM_REQS-1:0]  elig_rot;
    logic [IDX_W-1:0]     rot_off;
    logic [IDX_W:0]       win_sum;
    logic [IDX_W-1:0]     win_idx;
    logic                 slot_free;
    logic                 credit;
    logic                 grant_en;
    logic                 rsp_fire;
    logic                 win_rw;
    logic [OUT_AW-1:0]    win_addr;
    logic [DATA_WIDTH-1:0] win_data;
    logic [TAG_WIDTH-1:0] win_tag;
    logic [IDX_W-1:0]     rsp_idx;

    // Rotate eligibility so the search starts at rr_ptr, then map the offset back.
    always_comb begin
        elig_rot = NUM_REQS'({eligible, eligible} >> rr_ptr_q);
        rot_off  = '0;
        for (int k = int'(NUM_REQS) - 1; k >= 0; k--) begin
            if (elig_rot[k]) rot_off = IDX_W'(k);
        end
        win_sum = (IDX_W+1)'(rr_ptr_q) + (IDX_W+1)'(rot_off);
        if (win_sum >= (IDX_W+1)'(NUM_REQS)) win_sum = win_sum - (IDX_W+1)'(NUM_REQS);
    end

    assign win_idx   = win_sum[IDX_W-1:0];
    assign slot_free = !req_valid_q || bank_req_ready;
    assign credit    = pending_q < CNT_W'(MAX_PENDING);
    assign grant_en  = reset && slot_free && credit && (|eligible);
    assign rsp_fire  = bank_rsp_valid && bank_rsp_ready;

    always_comb begin
        win_rw    = 1'b0;
        win_addr  = '0;
        win_data  = '0;
        win_tag   = '0;
        req_ready = '0;
        for (int i = 0; i < int'(NUM_REQS); i++) begin
            if (win_idx == IDX_W'(i)) begin
                win_rw       = req_rw[i];
                win_addr     = strip_addr[i];
                win_data     = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                win_tag      = req_tag[i*TAG_WIDTH +: TAG_WIDTH];
                req_ready[i] = grant_en;
            end
        end
    end

    always_comb begin
        req_valid_d = req_valid_q;
        req_d       = req_q;
        rr_ptr_d    = rr_ptr_q;
        pending_d   = pending_q;

        if (grant_en) begin
            req_valid_d = 1'b1;
            req_d.rw    = win_rw;
            req_d.addr  = win_addr;
            req_d.data  = win_data;
            req_d.tag   = {win_tag, win_idx};
            rr_ptr_d    = (win_idx == IDX_W'(NUM_REQS - 1)) ? '0 : win_idx + IDX_W'(1);
        end else if (bank_req_ready) begin
            req_valid_d = 1'b0;
        end

        // A stray response at zero holds the counter rather than wrapping.
        if (grant_en && !rsp_fire) begin
            pending_d = pending_q + CNT_W'(1);
        end else if (!grant_en && rsp_fire && (pending_q != '0)) begin
            pending_d = pending_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_valid_q <= 1'b0;
            req_q       <= '0;
            rr_ptr_q    <= '0;
            pending_q   <= '0;
        end else begin
            req_valid_q <= req_valid_d;
            req_q       <= req_d;
            rr_ptr_q    <= rr_ptr_d;
            pending_q   <= pending_d;
        end
    end

    assign bank_req_valid = req_valid_q;
    assign bank_req_rw    = req_q.rw;
    assign bank_req_addr  = req_q.addr;
    assign bank_req_data  = req_q.data;
    assign bank_req_tag   = req_q.tag;

    // Response path is a pure pass-through steered by the index carried in the tag.
    assign rsp_idx  = bank_rsp_tag[IDX_W-1:0];
    assign rsp_tag  = bank_rsp_tag[OTAG_W-1:IDX_W];
    assign rsp_data = bank_rsp_data;

    always_comb begin
        rsp_valid      = '0;
        bank_rsp_ready = 1'b0;
        for (int i = 0; i < int'(NUM_REQS); i++) begin
            if (rsp_idx == IDX_W'(i)) begin
                rsp_valid[i]   = bank_rsp_valid;
                bank_rsp_ready = rsp_ready[i];
            end
        end
    end

    rsp_underflow_a: assert property (@(posedge clk) disable iff (!reset)
        rsp_fire |-> (pending_q != '0));

    rsp_idx_range_a: assert property (@(posedge clk) disable iff (!reset)
        bank_rsp_valid |-> (32'(rsp_idx) < NUM_REQS));

endmodule
